reorder_ma_gen: RTL and testbench



---
 rtl/reorder_ma_pkg.sv | 30 +++
 rtl/reorder_ma_digit_rev.sv | 17 +
 rtl/reorder_ma_gen.sv | 105 ++++++++++
 tb/tb_reorder_ma_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/reorder_ma_pkg.sv
// Shared types, default geometry and the digit-reverse helper for the R16 FFT
// memory-address reorder pipelines (forward and inverse).
package reorder_ma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_MA_WIDTH   = 11;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_REV_DIGITS = 2;

  // Digit k of the low field lands at digit position nd-1-k; bits above the
  // reversed field are copied through untouched.
  function automatic logic [31:0] digit_rev(input logic [31:0] v,
                                            input int dw,
                                            input int nd);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < nd; k++) begin
      for (int b = 0; b < dw; b++) begin
        r[(nd-1-k)*dw + b] = v[k*dw + b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ma_digit_rev.sv
// Combinational radix-2^DIGIT_W digit reversal of the low REV_DIGITS digits.
module reorder_ma_digit_rev
  import reorder_ma_pkg::*;
#(
  parameter int MA_WIDTH   = DEF_MA_WIDTH,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int REV_DIGITS = DEF_REV_DIGITS
) (
  input  logic [MA_WIDTH-1:0] idx,
  output logic [MA_WIDTH-1:0] ma
);

  always_comb begin
    ma = MA_WIDTH'(digit_rev(32'(idx), DIGIT_W, REV_DIGITS));
  end

endmodule

// File: rtl/reorder_ma_gen.sv
// Forward-reorder MA generator: sweeps 0..2^MA_WIDTH-1, digit-reverses, 2-cycle registered output.
// Optional REORDER_MA_PARITY_EN adds ma_par_o, the XOR of ma_o registered alongside it.
module reorder_ma_gen
  import reorder_ma_pkg::*;
#(
  parameter int MA_WIDTH   = DEF_MA_WIDTH,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int REV_DIGITS = DEF_REV_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                en_i,
  output logic                busy_o,
  output logic [MA_WIDTH-1:0] ma_o,
  output logic                ma_vld_o,
`ifdef REORDER_MA_PARITY_EN
  output logic                ma_par_o,
`endif
  output logic                done_o
);

  state_t              state;
  logic [MA_WIDTH-1:0] cnt;
  logic [MA_WIDTH-1:0] rev_ma;
  logic [MA_WIDTH-1:0] s0_ma;
  logic                s0_vld;
  logic                s0_last;
  logic                issue;

  assign issue = (state == RUN) && en_i;

  reorder_ma_digit_rev #(
    .MA_WIDTH   (MA_WIDTH),
    .DIGIT_W    (DIGIT_W),
    .REV_DIGITS (REV_DIGITS)
  ) u_digit_rev (
    .idx (cnt),
    .ma  (rev_ma)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_o   <= 1'b0;
      s0_ma    <= '0;
      s0_vld   <= 1'b0;
      s0_last  <= 1'b0;
      ma_o     <= '0;
      ma_vld_o <= 1'b0;
      done_o   <= 1'b0;
`ifdef REORDER_MA_PARITY_EN
      ma_par_o <= 1'b0;
`endif
    end else begin
      // Stage 0: a bubble keeps the old address but clears valid/last.
      s0_vld  <= issue;
      s0_last <= issue && (&cnt);
      if (issue) begin
        s0_ma <= rev_ma;
      end

      // Stage 1 (output): ma_o holds across bubbles.
      ma_vld_o <= s0_vld;
      done_o   <= s0_vld && s0_last;
      if (s0_vld) begin
        ma_o <= s0_ma;
`ifdef REORDER_MA_PARITY_EN
        ma_par_o <= ^s0_ma;
`endif
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= RUN;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        RUN: begin
          if (en_i) begin
            cnt <= cnt + MA_WIDTH'(1);
            if (&cnt) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // done_o marks the last address leaving; busy drops right after it.
          if (done_o) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_ma_gen.sv
// Self-checking bench for reorder_ma_gen against a cycle-level reference model.
module tb_reorder_ma_gen;

  localparam int N = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        en_i;
  logic        busy_o;
  logic [10:0] ma_o;
  logic        ma_vld_o;
  logic        done_o;
`ifdef REORDER_MA_PARITY_EN
  logic        ma_par_o;
`endif

  reorder_ma_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .en_i     (en_i),
    .busy_o   (busy_o),
    .ma_o     (ma_o),
    .ma_vld_o (ma_vld_o),
`ifdef REORDER_MA_PARITY_EN
    .ma_par_o (ma_par_o),
`endif
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: p0 is the index sitting in the first pipeline stage (-1 = bubble).
  int   m_idx  = 0;
  bit   m_run  = 0;
  bit   m_busy = 0;
  int   m_p0   = -1;
  bit   m_vld  = 0;
  bit   m_done = 0;
  int   m_ma   = 0;
  bit   m_par  = 0;
  int   n_vld  = 0;
  int   n_done = 0;

  function automatic int map_addr(input int c);
    return (c / 256) * 256 + (c % 16) * 16 + (c / 16) % 16;
  endfunction

  function automatic bit parity11(input int v);
    bit p;
    p = 0;
    for (int i = 0; i < 11; i++) p ^= v[i];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit e);
    int o;
    if (r) begin
      m_idx = 0; m_run = 0; m_busy = 0; m_p0 = -1;
      m_vld = 0; m_done = 0; m_ma = 0; m_par = 0;
    end else begin
      o    = m_p0;
      m_p0 = (m_run && e) ? m_idx : -1;
      if (m_run && e) begin
        if (m_idx == N - 1) m_run = 0;
        m_idx = (m_idx + 1) % N;
      end
      if (!m_busy && s) begin
        m_busy = 1; m_run = 1; m_idx = 0;
      end else if (m_busy && m_done) begin
        m_busy = 0;
      end
      m_vld  = (o >= 0);
      m_done = (o == N - 1);
      if (m_vld) begin
        m_ma  = map_addr(o);
        m_par = parity11(m_ma);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit e);
    rst = r; start_i = s; en_i = e;
    @(posedge clk);
    model_step(r, s, e);
    #1;
    chk("busy", 32'(busy_o), 32'(m_busy));
    chk("vld", 32'(ma_vld_o), 32'(m_vld));
    chk("done", 32'(done_o), 32'(m_done));
    chk("ma", 32'(ma_o), 32'(m_ma));
`ifdef REORDER_MA_PARITY_EN
    chk("par", 32'(ma_par_o), 32'(m_par));
`endif
    if (ma_vld_o === 1'b1) n_vld++;
    if (done_o === 1'b1) n_done++;
  endtask

  initial begin
    int v0, d0;
    bit s, e;

    rst = 1'b1; start_i = 1'b0; en_i = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);

    // Idle with enable but no start: nothing happens.
    for (int i = 0; i < 20; i++) cyc(0, 0, 1);

    // Sweep A: continuous enable.
    v0 = n_vld; d0 = n_done;
    cyc(0, 1, 1);
    for (int i = 0; i < N + 20; i++) begin
      cyc(0, 0, 1);
      if (!m_busy) break;
    end
    chk("sweepA_end_busy", 32'(busy_o), 32'd0);
    chk("sweepA_valids", 32'(n_vld - v0), 32'(N));
    chk("sweepA_dones", 32'(n_done - d0), 32'd1);

    // Sweep B: enable toggling 1,0,1,0.
    v0 = n_vld; d0 = n_done;
    cyc(0, 1, 1);
    for (int i = 0; i < 2 * N + 20; i++) begin
      cyc(0, 0, (i % 2) == 0);
      if (!m_busy) break;
    end
    chk("sweepB_end_busy", 32'(busy_o), 32'd0);
    chk("sweepB_valids", 32'(n_vld - v0), 32'(N));
    chk("sweepB_dones", 32'(n_done - d0), 32'd1);

    // Sweep C: random stalls, stray starts mid-sweep and one coincident with done.
    v0 = n_vld; d0 = n_done;
    cyc(0, 1, 1);
    for (int i = 0; i < 3 * N; i++) begin
      e = ($urandom_range(0, 3) != 0);
      s = m_done ? 1'b1 : ($urandom_range(0, 49) == 0);
      cyc(0, s, e);
      if (!m_busy) break;
    end
    chk("sweepC_end_busy", 32'(busy_o), 32'd0);
    chk("sweepC_valids", 32'(n_vld - v0), 32'(N));
    chk("sweepC_dones", 32'(n_done - d0), 32'd1);

    // Fresh start in the first not-busy cycle, then reset when index 0x400 is next.
    d0 = n_done;
    cyc(0, 1, 1);
    chk("restart_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (m_idx == 'h400) break;
      cyc(0, 0, 1);
    end
    chk("reached_0x400", 32'(m_idx), 32'h400);
    cyc(1, 0, 1);
    chk("rst_ma", 32'(ma_o), 32'd0);
    chk("rst_vld", 32'(ma_vld_o), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    chk("rst_no_done", 32'(n_done - d0), 32'd0);

    // Full sweep after the mid-sweep reset.
    v0 = n_vld; d0 = n_done;
    cyc(0, 1, 1);
    for (int i = 0; i < N + 20; i++) begin
      cyc(0, 0, 1);
      if (!m_busy) break;
    end
    chk("sweepD_valids", 32'(n_vld - v0), 32'(N));
    chk("sweepD_dones", 32'(n_done - d0), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
